// File: rtl/data_types_pkg.sv
// Shared types and helpers for the data_types round-robin arbiter.
//   arb_state_t : sequencer states (IDLE -> WAIT -> RESP -> IDLE)
//   id_width()  : width of a requester index, never narrower than 1 bit
package data_types_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // max(1, clog2(n)): a single requester still needs a 1-bit ID
   function automatic int id_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search.
//   req_valid [NUM_REQ]  : per-requester request
//   rr_ptr    [ID_W]     : first index to consider
//   grant_vld            : some requester is valid
//   grant_idx [ID_W]     : first valid index at or after rr_ptr (mod NUM_REQ)
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               grant_vld,
   output logic [ID_W-1:0]    grant_idx
);

   // Scan offsets from farthest to nearest so the nearest valid requester wins
   always_comb begin
      int raw_s;
      int idx_s;
      grant_vld = 1'b0;
      grant_idx = '0;
      raw_s     = 0;
      idx_s     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         raw_s = int'(rr_ptr) + k;
         if (raw_s >= NUM_REQ) begin
            idx_s = raw_s - NUM_REQ;
         end else begin
            idx_s = raw_s;
         end
         if (req_valid[idx_s]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(idx_s);
         end else begin
            grant_vld = grant_vld;
         end
      end
   end

endmodule

// File: rtl/data_types_arbiter.sv
// Round-robin sequencer sharing one external data_types datapath among
// NUM_REQ requesters; exactly one operation is in flight at a time.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot, IDLE only)
//   req_a/req_b         : packed operands, requester i at [i*IW +: IW]
//   dp_a/dp_b           : operands driven to the datapath (held after use)
//   dp_c/dp_d           : datapath results, captured DP_LATENCY cycles later
//   rsp_valid/rsp_ready : result handshake; rsp_id/rsp_c/rsp_d stable while waiting
//   busy                : sequencer not in IDLE
module data_types_arbiter
   import data_types_pkg::*;
#(
   parameter  int INPUT_WIDTH  = 4,
   parameter  int OUTPUT_WIDTH = INPUT_WIDTH * 2,
   parameter  int NUM_REQ      = 4,
   parameter  int DP_LATENCY   = 0,
   localparam int ID_W         = id_width(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
   output logic [INPUT_WIDTH-1:0]         dp_a,
   output logic [INPUT_WIDTH-1:0]         dp_b,
   input  logic [OUTPUT_WIDTH-1:0]        dp_c,
   input  logic [OUTPUT_WIDTH-1:0]        dp_d,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ID_W-1:0]                rsp_id,
   output logic [OUTPUT_WIDTH-1:0]        rsp_c,
   output logic [OUTPUT_WIDTH-1:0]        rsp_d,
   output logic                           busy
);

   // Counter must be able to hold DP_LATENCY itself
   localparam int CNT_W = id_width(DP_LATENCY + 1);

   arb_state_t              state_q, state_d;
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]         id_q, id_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [INPUT_WIDTH-1:0]  dp_a_q, dp_a_d;
   logic [INPUT_WIDTH-1:0]  dp_b_q, dp_b_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
   logic [OUTPUT_WIDTH-1:0] rsp_c_q, rsp_c_d;
   logic [OUTPUT_WIDTH-1:0] rsp_d_q, rsp_d_d;
   logic                    grant_vld_s;
   logic [ID_W-1:0]         grant_idx_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant_vld (grant_vld_s),
      .grant_idx (grant_idx_s)
   );

   // State and datapath registers; reset abandons any in-flight operation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_c_q     <= '0;
         rsp_d_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         dp_a_q      <= dp_a_d;
         dp_b_q      <= dp_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_c_q     <= rsp_c_d;
         rsp_d_q     <= rsp_d_d;
      end
   end

   // Next-state logic and grant-side ready
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      dp_a_d      = dp_a_q;
      dp_b_d      = dp_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_c_d     = rsp_c_q;
      rsp_d_d     = rsp_d_q;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld_s) begin
               req_ready[grant_idx_s] = 1'b1;
               dp_a_d  = req_a[int'(grant_idx_s)*INPUT_WIDTH +: INPUT_WIDTH];
               dp_b_d  = req_b[int'(grant_idx_s)*INPUT_WIDTH +: INPUT_WIDTH];
               id_d    = grant_idx_s;
               cnt_d   = CNT_W'(DP_LATENCY);
               state_d = WAIT;
               // Explicit wrap keeps rr_ptr constant 0 when NUM_REQ=1
               if (int'(grant_idx_s) == NUM_REQ - 1) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_idx_s + ID_W'(1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               rsp_c_d     = dp_c;
               rsp_d_d     = dp_d;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   assign dp_a      = dp_a_q;
   assign dp_b      = dp_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_d     = rsp_d_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_types_arbiter.sv
module tb_data_types_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready;
   logic [15:0] req_a, req_b;
   logic [3:0]  dp_a, dp_b;
   logic [7:0]  dp_c, dp_d;
   logic        rsp_valid, rsp_ready, busy;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_c, rsp_d;

   logic [3:0]  req_valid2, req_ready2;
   logic [3:0]  dp_a2, dp_b2;
   logic [7:0]  dp_c2, dp_d2;
   logic        rsp_valid2, rsp_ready2, busy2;
   logic [1:0]  rsp_id2;
   logic [7:0]  rsp_c2, rsp_d2;
   logic [7:0]  p1_c, p1_d, p2_c, p2_d;

   int n_chk  = 0;
   int n_fail = 0;

   data_types_arbiter #(.INPUT_WIDTH(4), .NUM_REQ(4), .DP_LATENCY(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_c(rsp_c), .rsp_d(rsp_d), .busy(busy));

   data_types_arbiter #(.INPUT_WIDTH(4), .NUM_REQ(4), .DP_LATENCY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_a(req_a), .req_b(req_b), .dp_a(dp_a2), .dp_b(dp_b2), .dp_c(dp_c2), .dp_d(dp_d2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
      .rsp_c(rsp_c2), .rsp_d(rsp_d2), .busy(busy2));

   // Datapath stand-in: c = a*b, d = {a, ~b}
   function automatic logic [7:0] mdl_c(input logic [3:0] a, input logic [3:0] b);
      return {4'b0, a} * {4'b0, b};
   endfunction
   function automatic logic [7:0] mdl_d(input logic [3:0] a, input logic [3:0] b);
      return {a, ~b};
   endfunction

   assign dp_c  = mdl_c(dp_a, dp_b);
   assign dp_d  = mdl_d(dp_a, dp_b);
   assign dp_c2 = p2_c;
   assign dp_d2 = p2_d;

   // Two-stage datapath for the DP_LATENCY=2 instance
   always_ff @(posedge clk) begin
      p1_c <= mdl_c(dp_a2, dp_b2);
      p1_d <= mdl_d(dp_a2, dp_b2);
      p2_c <= p1_c;
      p2_d <= p1_d;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] a;
      logic [15:0] b;
      int          exp_id;
   } vec_t;

   // One full operation with DP_LATENCY=0 and rsp_ready given on the first RESP cycle
   task automatic run_op(input vec_t v);
      logic [3:0] ea, eb;
      ea = v.a[v.exp_id*4 +: 4];
      eb = v.b[v.exp_id*4 +: 4];
      req_valid = v.valid; req_a = v.a; req_b = v.b; rsp_ready = 1'b0;
      #1;
      chk("req_ready_T", 32'(req_ready), 32'(4'b0001 << v.exp_id));
      step();
      req_valid = 4'b0000;
      #1;
      chk("dp_a_T1", 32'(dp_a), 32'(ea));
      chk("dp_b_T1", 32'(dp_b), 32'(eb));
      chk("busy_T1", 32'(busy), 32'd1);
      chk("rsp_valid_T1", 32'(rsp_valid), 32'd0);
      step();
      chk("rsp_valid_T2", 32'(rsp_valid), 32'd1);
      chk("rsp_id_T2", 32'(rsp_id), 32'(v.exp_id));
      chk("rsp_c_T2", 32'(rsp_c), 32'(mdl_c(ea, eb)));
      chk("rsp_d_T2", 32'(rsp_d), 32'(mdl_d(ea, eb)));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
      chk("rsp_c_hold", 32'(rsp_c), 32'(mdl_c(ea, eb)));
   endtask

   initial begin
      vec_t vecs[7];
      int   order[5];
      vecs[0] = '{4'b0010, 16'h0010, 16'h0020, 1}; // ptr 0 -> grant 1, ptr 2
      vecs[1] = '{4'b0011, 16'h00F7, 16'h0035, 0}; // ptr 2 wraps -> grant 0
      vecs[2] = '{4'b0011, 16'h00E0, 16'h00C0, 1}; // ptr 1 -> grant 1
      vecs[3] = '{4'b1001, 16'hF00A, 16'hB006, 3}; // ptr 2 -> grant 3
      vecs[4] = '{4'b1001, 16'h000F, 16'h000F, 0}; // ptr 0 -> grant 0
      vecs[5] = '{4'b0100, 16'h0C00, 16'h0700, 2}; // ptr 1 -> grant 2
      vecs[6] = '{4'b0111, 16'h0003, 16'h0008, 0}; // ptr 3 -> grant 0, ptr 1
      order   = '{0, 1, 2, 3, 0};

      rst_n = 1'b0; req_valid = '0; req_valid2 = '0; req_a = '0; req_b = '0;
      rsp_ready = 1'b0; rsp_ready2 = 1'b0;
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_dp_a", 32'(dp_a), 32'd0);
      chk("rst_dp_b", 32'(dp_b), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_c", 32'(rsp_c), 32'd0);
      chk("rst_rsp_d", 32'(rsp_d), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Table-driven single operations (includes wrap-around search)
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i]);
      end

      // Response stall: ptr 1, only req 2 valid -> grant 2
      req_valid = 4'b0100; req_a = 16'h0A00; req_b = 16'h0300;
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = 4'b1111;
      #1;
      chk("stall_wait_ready", 32'(req_ready), 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_id", 32'(rsp_id), 32'd2);
         chk("stall_rsp_c", 32'(rsp_c), 32'h1E);
         chk("stall_rsp_d", 32'(rsp_d), 32'hAC);
         chk("stall_req_ready0", 32'(req_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("hs_no_accept", 32'(req_ready), 32'd0);
      step();
      req_valid = 4'b0000; rsp_ready = 1'b0;
      #1;
      chk("stall_done_busy", 32'(busy), 32'd0);
      chk("stall_done_valid", 32'(rsp_valid), 32'd0);

      // Reset during WAIT: ptr 3, req 1 -> grant 1, then reset abandons it
      req_valid = 4'b0010; req_a = 16'h00B0; req_b = 16'h0040;
      #1;
      chk("rw_req_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 4'b0000; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rw_req_ready0", 32'(req_ready), 32'd0);
      chk("rw_dp_a", 32'(dp_a), 32'd0);
      chk("rw_dp_b", 32'(dp_b), 32'd0);
      chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rw_rsp_id", 32'(rsp_id), 32'd0);
      chk("rw_rsp_c", 32'(rsp_c), 32'd0);
      chk("rw_rsp_d", 32'(rsp_d), 32'd0);
      chk("rw_busy", 32'(busy), 32'd0);
      step();
      chk("rw_no_rsp", 32'(rsp_valid), 32'd0);

      // All requesters valid after reset: grants 0,1,2,3,0 every 3 cycles
      req_valid = 4'b1111; rsp_ready = 1'b1; req_a = 16'h4321; req_b = 16'h5678;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (c % 3 == 0) begin
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << order[c / 3]));
         end else begin
            chk("rr_no_grant", 32'(req_ready), 32'd0);
         end
         if (c % 3 == 2) begin
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(order[c / 3]));
         end
         step();
      end
      req_valid = 4'b0000; rsp_ready = 1'b0;

      // DP_LATENCY=2: a=1101, b=1001 from req 0
      req_valid2 = 4'b0001; req_a = 16'h000D; req_b = 16'h0009; rsp_ready2 = 1'b0;
      #1;
      chk("l2_req_ready", 32'(req_ready2), 32'h1);
      step();
      req_valid2 = 4'b0000;
      chk("l2_dp_a", 32'(dp_a2), 32'hD);
      chk("l2_dp_b", 32'(dp_b2), 32'h9);
      chk("l2_valid_T1", 32'(rsp_valid2), 32'd0);
      step();
      chk("l2_valid_T2", 32'(rsp_valid2), 32'd0);
      step();
      chk("l2_valid_T3", 32'(rsp_valid2), 32'd0);
      chk("l2_busy_T3", 32'(busy2), 32'd1);
      step();
      chk("l2_valid_T4", 32'(rsp_valid2), 32'd1);
      chk("l2_rsp_id", 32'(rsp_id2), 32'd0);
      chk("l2_rsp_c", 32'(rsp_c2), 32'h75);
      chk("l2_rsp_d", 32'(rsp_d2), 32'hD6);
      rsp_ready2 = 1'b1;
      step();
      rsp_ready2 = 1'b0;
      chk("l2_done", 32'(rsp_valid2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
